// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter family.
package cnt_pkg;

  localparam int              BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
  localparam int              MAX_DIGITS = 8;

  // Converts an integer to a packed BCD vector, digit 0 in the low nibble.
  function automatic logic [MAX_DIGITS*BCD_W-1:0] to_bcd(input int unsigned value);
    logic [MAX_DIGITS*BCD_W-1:0] r;
    int unsigned                 v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/cnt_bcd_multi_digit.sv
// One BCD digit of the counter chain: rolls 9->0 on inc and 0->9 on dec.
module bcd_digit
  import cnt_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic             clr,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             carry,
  output logic             borrow
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + 1'b1;
    end else if (dec) begin
      q <= (q == '0) ? BCD_MAX : q - 1'b1;
    end
  end

  assign carry  = inc & (q == BCD_MAX);
  assign borrow = dec & (q == '0);

endmodule

// File: rtl/cnt_bcd_multi.sv
// Multi-digit BCD up/down counter with programmable modulus, wrap/saturate and cascade carry.
module cnt_bcd_multi
  import cnt_pkg::*;
#(
  parameter int N_DIGITS = 2,
  parameter int MOD      = 60,
  parameter int WRAP     = 1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [BCD_W*N_DIGITS-1:0] load_val,
  output logic [BCD_W*N_DIGITS-1:0] cnt,
  output logic                      co,
  output logic                      load_err
);

  localparam int                          CNT_W    = BCD_W*N_DIGITS;
  localparam logic [MAX_DIGITS*BCD_W-1:0] TERM_ALL = to_bcd(MOD - 1);
  localparam logic [CNT_W-1:0]            TERM     = TERM_ALL[CNT_W-1:0];
  localparam logic                        WRAP_EN  = (WRAP != 0);

  logic             digits_ok;
  logic             load_ok;
  logic             at_top;
  logic             at_zero;
  logic             idle_en;
  logic             dig_clr;
  logic             dig_load;
  logic [CNT_W-1:0] dig_d;
  logic [N_DIGITS:0] inc_c;
  logic [N_DIGITS:0] dec_c;
  logic             unused_chain;

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!is_bcd(load_val[i*BCD_W +: BCD_W])) digits_ok = 1'b0;
    end
  end

  // With every digit valid, BCD ordering matches numeric ordering.
  assign load_ok = digits_ok & (load_val <= TERM);

  assign at_top  = (cnt == TERM);
  assign at_zero = (cnt == '0);
  assign idle_en = en & ~clr & ~load;
  assign co      = idle_en & (up ? at_top : at_zero);

  // Terminal-value wrap reuses the digit clear/load paths; saturation simply withholds the step.
  assign dig_clr  = clr | (WRAP_EN & idle_en & up & at_top);
  assign dig_load = ~clr & ((load & load_ok) | (WRAP_EN & idle_en & ~up & at_zero));
  assign dig_d    = load ? load_val : TERM;

  assign inc_c[0] = idle_en & up & ~at_top;
  assign dec_c[0] = idle_en & ~up & ~at_zero;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .inc       (inc_c[g]),
      .dec       (dec_c[g]),
      .load      (dig_load),
      .clr       (dig_clr),
      .d         (dig_d[g*BCD_W +: BCD_W]),
      .q         (cnt[g*BCD_W +: BCD_W]),
      .carry     (inc_c[g+1]),
      .borrow    (dec_c[g+1])
    );
  end

  // Below the terminal value the top digit can never carry or borrow out.
  assign unused_chain = inc_c[N_DIGITS] ^ dec_c[N_DIGITS];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= ~clr & load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_cnt_bcd_multi.sv
// Scoreboard bench: seconds (wrap), seconds (saturate) and a cascaded hours counter.
module tb_cnt_bcd_multi;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       en, up, clr, load, h_clr;
  logic [7:0] load_val;
  logic [7:0] w_cnt, s_cnt, h_cnt;
  logic       w_co, s_co, h_co;
  logic       w_err, s_err, h_err;

  cnt_bcd_multi #(.N_DIGITS(2), .MOD(60), .WRAP(1)) u_w (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cnt(w_cnt), .co(w_co), .load_err(w_err));

  cnt_bcd_multi #(.N_DIGITS(2), .MOD(60), .WRAP(0)) u_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .cnt(s_cnt), .co(s_co), .load_err(s_err));

  cnt_bcd_multi #(.N_DIGITS(2), .MOD(24), .WRAP(1)) u_h (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(w_co), .up(1'b1), .clr(h_clr), .load(1'b0),
    .load_val(8'h00), .cnt(h_cnt), .co(h_co), .load_err(h_err));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  localparam int S_WCNT = 0, S_WCO = 1, S_WERR = 2, S_SCNT = 3, S_SCO = 4, S_HCNT = 5, S_SERR = 6;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input int m);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (int'(v[7:4]) * 10 + int'(v[3:0]) < m);
  endfunction

  task automatic push_exp(input string name, input int sig, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Inputs change just after the rising edge; expectations describe this cycle's outputs.
  task automatic cyc(input logic e_, input logic u_, input logic c_, input logic l_,
                     input logic [7:0] lv);
    @(posedge sys_clk);
    #1;
    en = e_; up = u_; clr = c_; load = l_; load_val = lv;
  endtask

  // Monitor: compares every pending expectation against the outputs on the falling edge.
  always @(negedge sys_clk) begin
    logic [7:0] act;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      case (e.sig)
        S_WCNT:  act = w_cnt;
        S_WCO:   act = {7'd0, w_co};
        S_WERR:  act = {7'd0, w_err};
        S_SCNT:  act = s_cnt;
        S_SCO:   act = {7'd0, s_co};
        S_HCNT:  act = h_cnt;
        default: act = {7'd0, s_err};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
    total++;
    if (!(bcd_ok(w_cnt, 60) && bcd_ok(s_cnt, 60) && bcd_ok(h_cnt, 24))) begin
      bad++;
      $display("FAIL bcd_range: got w=%h s=%h h=%h want valid BCD below modulus (t=%0t)",
               w_cnt, s_cnt, h_cnt, $time);
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    en = 0; up = 0; clr = 0; load = 0; h_clr = 0; load_val = 8'h00;

    @(posedge sys_clk); #1;
    push_exp("rst_wcnt", S_WCNT, 8'h00);
    push_exp("rst_werr", S_WERR, 8'h00);
    push_exp("rst_scnt", S_SCNT, 8'h00);
    push_exp("rst_hcnt", S_HCNT, 8'h00);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // Asynchronous reset from the middle of a count
    cyc(0, 0, 0, 1, 8'h37);
    push_exp("ld37_co", S_WCO, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    push_exp("ld37_cnt", S_WCNT, 8'h37);
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    push_exp("async_rst_cnt", S_WCNT, 8'h00);
    push_exp("async_rst_err", S_WERR, 8'h00);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // Up count over the full modulus: wrap instance returns to 00, saturate holds at 59
    for (int k = 0; k <= 60; k++) begin
      cyc(k < 60, 1, 0, 0, 8'h00);
      push_exp($sformatf("up_w_cnt[%0d]", k), S_WCNT, bcd2(k % 60));
      push_exp($sformatf("up_w_co[%0d]", k), S_WCO, {7'd0, k == 59});
      push_exp($sformatf("up_s_cnt[%0d]", k), S_SCNT, bcd2(k < 59 ? k : 59));
      push_exp($sformatf("up_s_co[%0d]", k), S_SCO, {7'd0, k == 59});
    end

    // Load acceptance and rejection
    cyc(0, 0, 0, 1, 8'h42);
    cyc(0, 0, 0, 1, 8'h1A);
    push_exp("ld42_cnt", S_WCNT, 8'h42);
    push_exp("ld42_err", S_WERR, 8'h00);
    push_exp("ld42_scnt", S_SCNT, 8'h42);
    cyc(0, 0, 0, 1, 8'h60);
    push_exp("ld1A_cnt", S_WCNT, 8'h42);
    push_exp("ld1A_err", S_WERR, 8'h01);
    push_exp("ld1A_serr", S_SERR, 8'h01);
    cyc(0, 0, 0, 0, 8'h00);
    push_exp("ld60_cnt", S_WCNT, 8'h42);
    push_exp("ld60_err", S_WERR, 8'h01);
    cyc(0, 0, 0, 0, 8'h00);
    push_exp("err_clear", S_WERR, 8'h00);

    // Down count from zero: wrap to 59 versus hold at 00
    cyc(0, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    push_exp("dn0_w_cnt", S_WCNT, 8'h00);
    push_exp("dn0_w_co", S_WCO, 8'h01);
    push_exp("dn0_s_co", S_SCO, 8'h01);
    cyc(1, 0, 0, 0, 8'h00);
    push_exp("dn1_w_cnt", S_WCNT, 8'h59);
    push_exp("dn1_w_co", S_WCO, 8'h00);
    push_exp("dn1_s_cnt", S_SCNT, 8'h00);
    push_exp("dn1_s_co", S_SCO, 8'h01);
    cyc(0, 0, 0, 1, 8'h10);
    push_exp("dn2_w_cnt", S_WCNT, 8'h58);
    push_exp("dn2_s_cnt", S_SCNT, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    push_exp("bor_start", S_WCNT, 8'h10);
    push_exp("bor_co", S_WCO, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    push_exp("bor_10_09", S_WCNT, 8'h09);

    // Priority: clr over load over en, and co suppressed by load
    cyc(0, 0, 0, 1, 8'h25);
    cyc(1, 1, 1, 1, 8'h1A);
    push_exp("pri_pre_cnt", S_WCNT, 8'h25);
    push_exp("pri_clr_co", S_WCO, 8'h00);
    cyc(0, 0, 0, 1, 8'h59);
    push_exp("pri_clr_cnt", S_WCNT, 8'h00);
    push_exp("pri_clr_err", S_WERR, 8'h00);
    cyc(1, 1, 0, 1, 8'h10);
    push_exp("pri_ld_pre", S_WCNT, 8'h59);
    push_exp("pri_ld_co", S_WCO, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    push_exp("pri_ld_cnt", S_WCNT, 8'h10);

    // Cascade: seconds carry drives the hours enable through a full day
    cyc(0, 0, 1, 0, 8'h00);
    h_clr = 1'b1;
    for (int k = 0; k <= 1440; k++) begin
      cyc(k < 1440, 1, 0, 0, 8'h00);
      h_clr = 1'b0;
      push_exp($sformatf("cas_s[%0d]", k), S_WCNT, bcd2(k % 60));
      push_exp($sformatf("cas_h[%0d]", k), S_HCNT, bcd2((k / 60) % 24));
    end

    cyc(0, 0, 0, 0, 8'h00);
    @(posedge sys_clk);
    @(posedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_bcd_multi.md
Name: cnt_bcd_multi

Overview:
- Parametrised multi-digit BCD counter; successor to the single-digit decade counter in the timing/counter library.
- Counts up or down over a programmable decimal modulus (e.g. 60 for seconds/minutes, 24 for hours, 1000 for ms), with synchronous load, synchronous clear, wrap or saturate mode, and a cascade carry/borrow output.
- Used in the clock/stopwatch datapath, cascaded digit-chains driven by a 1 Hz enable strobe.

Parameters:
- N_DIGITS, 2, number of BCD digits (1..8); count bus width 4*N_DIGITS.
- MOD, 60, decimal modulus; count range 0..MOD-1; legal 2 <= MOD <= 10**N_DIGITS.
- WRAP, 1, 1 = wrap at terminal value; 0 = saturate (hold) at terminal value.

Ports:
- sys_clk  in  1  system clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable (single-cycle strobe from prescaler or upstream co).
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  4*N_DIGITS  BCD load value, digit 0 in bits [3:0].
- cnt  out  4*N_DIGITS  current BCD count, digit 0 = least significant.
- co  out  1  combinational cascade carry/borrow.
- load_err  out  1  registered one-cycle flag: rejected load.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): cnt = 0, load_err = 0, independent of clock.
- Priority per clock edge: clr > load > en. Exactly one action per cycle; no action leaves cnt unchanged.
- clr: cnt <= 0; load_err <= 0.
- load: accepted if every digit of load_val <= 9 and decimal value < MOD -> cnt <= load_val, load_err <= 0. Otherwise cnt unchanged, load_err <= 1 for exactly one cycle.
- load_err is 0 in any cycle without a rejected load.
- en & up:
  - cnt < MOD-1: decimal increment; each digit rolls 9->0 with carry into the next digit.
  - cnt == MOD-1: WRAP=1 -> cnt <= 0; WRAP=0 -> hold at MOD-1.
- en & !up:
  - cnt > 0: decimal decrement; each digit rolls 0->9 with borrow.
  - cnt == 0: WRAP=1 -> cnt <= MOD-1; WRAP=0 -> hold at 0.
- co = en & !clr & !load & ((up & cnt == MOD-1) | (!up & cnt == 0)).
  - Asserted in the cycle before wrap/saturation; zero latency, so a downstream instance's en may be tied to it.
  - co asserts at the terminal value in both WRAP modes.
- cnt never holds a non-BCD digit or a value >= MOD; the invariant holds under all input sequences.
- en high with load or clr in the same cycle: en is ignored; co is suppressed.
- Reset asserted mid-count: immediate return to 0; the first edge after deassert acts on the inputs normally.
- Latency: cnt updates one edge after en/load/clr sampled.

Decomposition:
- Shared package cnt_pkg: localparam BCD_W = 4, BCD_MAX = 4'd9; function to convert an integer modulus to a BCD constant (MOD-1 terminal vector); function is_bcd(digit).
- Sub-module bcd_digit: one 4-bit digit.
  - Inputs: inc, dec, load, clr, d.
  - Outputs: q, carry (q==9 & inc), borrow (q==0 & dec).
  - Top generates N_DIGITS instances, ripples carry/borrow, and overrides with terminal/wrap logic at the top level.

Test Plan:
- Reset: hold sys_rst_n=0 mid-count at cnt=8'h37, asynchronously -> cnt=8'h00, load_err=0 before next edge.
- Up wrap (N_DIGITS=2, MOD=60, WRAP=1): en=1, up=1 from 0 for 60 cycles -> 00..09,10..59,00; co high only while cnt=8'h59; digit rollover 09->10 verified.
- Down wrap and saturate: load 8'h00, en=1, up=0 -> WRAP=1 gives 8'h59 with co=1 in the prior cycle; WRAP=0 instance stays 8'h00, co=1 each enabled cycle.
- Load checks: load_val=8'h42 -> cnt=8'h42, load_err=0; load_val=8'h1A (digit > 9) and 8'h60 (>= MOD) -> cnt unchanged, load_err=1 for one cycle each.
- Priority: clr=1, load=1, en=1 at cnt=8'h25 -> cnt=8'h00; load=1, en=1 with load_val=8'h10 -> cnt=8'h10, co=0.
- Cascade: MOD=60 seconds co -> en of MOD=24 hours instance; run 60*24 enables -> hours 00..23..00, both cnt always valid BCD (assertion).
